// File: rtl/acc_seq_ctrl.sv
// Skew-aware capture of systolic column results into a ROWS x COLS bank, then a row-by-row drain.
// Optional build macro ACC_SAT_EN: accumulate-mode addition saturates (signed) instead of wrapping.
module acc_seq_ctrl #(
    parameter int DATA_W   = 32,
    parameter int NUM_COLS = 2,
    parameter int MAX_ROWS = 4,
    parameter int LAT      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          accumulate,
    input  logic [$clog2(MAX_ROWS+1)-1:0] num_rows,
    input  logic [NUM_COLS*DATA_W-1:0]    col_in,
    output logic                          busy,
    output logic                          full,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_COLS*DATA_W-1:0]    out_data,
    output logic [$clog2(MAX_ROWS)-1:0]   out_row,
    output logic                          done,
    output logic                          error
);
    localparam int NR_W  = $clog2(MAX_ROWS+1);
    localparam int ROW_W = $clog2(MAX_ROWS);
    localparam int CNT_W = $clog2(LAT + MAX_ROWS + NUM_COLS + 1);
`ifdef ACC_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         t_last;
    logic [NR_W-1:0]          n_rows;
    logic                     acc_q;
    logic [ROW_W-1:0]         row;
    logic                     error_q;
    logic                     last_sample;
    logic                     last_row;
    logic signed [DATA_W-1:0] bank     [MAX_ROWS][NUM_COLS];
    logic signed [DATA_W-1:0] col_word [NUM_COLS];

    function automatic logic signed [DATA_W-1:0] acc_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
`ifdef ACC_SAT_EN
        if (sum[DATA_W] != sum[DATA_W-1])
            return sum[DATA_W] ? SAT_MIN : SAT_MAX;
`endif
        return sum[DATA_W-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_COLS; c++)
            col_word[c] = col_in[c*DATA_W +: DATA_W];
    end

    // The last sample lands on the bottom-right cell: row N-1, column NUM_COLS-1.
    assign t_last      = CNT_W'(LAT + NUM_COLS - 2) + CNT_W'(n_rows);
    assign last_sample = (state == S_CAPTURE) && (cnt == t_last);
    assign last_row    = (NR_W'(row) == (n_rows - NR_W'(1)));

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        full      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (num_rows == '0) ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                busy = 1'b1;
                if (last_sample)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                full      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && last_row)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job configuration, cycle counter and drain row pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            n_rows  <= '0;
            acc_q   <= 1'b0;
            row     <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt    <= CNT_W'(1);
                        n_rows <= (num_rows > NR_W'(MAX_ROWS)) ? NR_W'(MAX_ROWS) : num_rows;
                        acc_q  <= accumulate;
                        row    <= '0;
                    end
                end
                S_CAPTURE: cnt <= cnt + CNT_W'(1);
                S_DRAIN: begin
                    if (out_ready)
                        row <= last_row ? '0 : row + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Each cell has exactly one capture cycle; col_in is don't-care everywhere else.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < MAX_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++)
                    bank[r][c] <= '0;
        end else if (state == S_CAPTURE) begin
            for (int r = 0; r < MAX_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++)
                    if ((NR_W'(r) < n_rows) && (cnt == CNT_W'(LAT + r + c)))
                        bank[r][c] <= acc_q ? acc_add(bank[r][c], col_word[c]) : col_word[c];
        end
    end

    always_comb begin
        out_data = '0;
        if (state == S_DRAIN)
            for (int c = 0; c < NUM_COLS; c++)
                out_data[c*DATA_W +: DATA_W] = bank[row][c];
    end

    assign out_row = row;
    assign error   = error_q;

endmodule
